// File: rtl/picam_pkg.sv
// picam_pkg
// Shared types and constants for the PICAM front-end sequencer.
//   seq_state_t : sequencer FSM states; the encoding is what appears on state_o
//   OP_*        : command opcodes carried in payload[4:3] of a command frame
//   FRAME_W     : payload bits per frame
//   INSTR_W     : instruction width, built from a lo frame followed by a hi frame
package picam_pkg;

  localparam int FRAME_W = 5;
  localparam int INSTR_W = 2 * FRAME_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L_ADDR  = 3'd1,
    L_LO    = 3'd2,
    L_HI    = 3'd3,
    WRITE   = 3'd4,
    RUN_RST = 3'd5,
    RUN     = 3'd6
  } seq_state_t;

  localparam logic [1:0] OP_STEP = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

endpackage

// File: rtl/picam_frame_rx.sv
// picam_frame_rx
// Detects frames on the shared input bus. A frame is the rising edge of the
// strobe bit; its payload is the low bits of the bus in that same cycle.
// Ports:
//   i_clock       : system clock
//   i_reset       : synchronous, active-high reset
//   i_in_bus      : [FRAME_W] = strobe, [FRAME_W-1:0] = payload
//   o_frame_valid : one-cycle pulse in the cycle the strobe rises
//   o_frame_data  : payload, valid when o_frame_valid is high
module picam_frame_rx
  import picam_pkg::*;
(
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [FRAME_W:0]   i_in_bus,
  output logic               o_frame_valid,
  output logic [FRAME_W-1:0] o_frame_data
);

  logic r_strb_q;
  logic w_strb;

  assign w_strb = i_in_bus[FRAME_W];

  // r_strb_q resets high so a strobe that is already high when reset
  // releases is treated as old, not as a fresh edge.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_strb_q <= 1'b1;
    end else begin
      r_strb_q <= w_strb;
    end
  end

  assign o_frame_valid = w_strb & ~r_strb_q;
  assign o_frame_data  = i_in_bus[FRAME_W-1:0];

endmodule

// File: rtl/picam_seq_ctrl.sv
// picam_seq_ctrl
// Front-end sequencer for the PICAM core. Decodes strobed frames into either
// program-memory loads (LOAD, addr, lo, hi) or core sequencing commands
// (STEP, RUN, RUN-resume, HALT). It owns the core clock-enable and reset, and
// the core is never enabled while a load is in progress.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for a command frame, core stopped
//   L_ADDR  | load: waiting for the address frame
//   L_LO    | load: waiting for the low instruction frame
//   L_HI    | load: waiting for the high instruction frame
//   WRITE   | one-cycle program-memory write strobe
//   RUN_RST | one-cycle core reset before running
//   RUN     | core enabled every cycle until HALT
//
// Ports:
//   clock        : system clock
//   reset        : synchronous, active-high reset
//   in_bus       : [5] frame strobe, [4:0] payload
//   mem_we       : program-memory write strobe (one cycle)
//   mem_addr     : write address
//   mem_wdata    : write data {hi, lo}
//   core_en      : core clock-enable
//   core_rst     : core reset pulse
//   busy         : load sequence in progress
//   words_loaded : completed writes, saturating at 255
//   state_o      : current FSM state (debug)
module picam_seq_ctrl
  import picam_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [FRAME_W:0]   in_bus,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               core_en,
  output logic               core_rst,
  output logic               busy,
  output logic [7:0]         words_loaded,
  output logic [2:0]         state_o
);

  logic               w_frame_valid;
  logic [FRAME_W-1:0] w_frame_data;
  logic [1:0]         w_op;
  logic               w_resume;

  seq_state_t         r_state;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [INSTR_W-1:0] r_mem_wdata;
  logic               r_core_en;
  logic               r_core_rst;
  logic               r_busy;
  logic [7:0]         r_words_loaded;

  picam_frame_rx u_frame_rx (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_in_bus      (in_bus),
    .o_frame_valid (w_frame_valid),
    .o_frame_data  (w_frame_data)
  );

  assign w_op     = w_frame_data[FRAME_W-1:FRAME_W-2];
  assign w_resume = w_frame_data[0];

  // Single registered FSM. Pulsed outputs (mem_we, core_rst) and core_en
  // default low each cycle and are raised on the transition into the state
  // that owns them, so they line up with that state's cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= IDLE;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_core_en      <= 1'b0;
      r_core_rst     <= 1'b0;
      r_busy         <= 1'b0;
      r_words_loaded <= '0;
    end else begin
      r_mem_we   <= 1'b0;
      r_core_rst <= 1'b0;
      r_core_en  <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_frame_valid) begin
            case (w_op)
              OP_LOAD: begin
                r_state <= L_ADDR;
                r_busy  <= 1'b1;
              end
              OP_STEP: begin
                r_core_en <= 1'b1;
              end
              OP_RUN: begin
                if (w_resume) begin
                  r_state   <= RUN;
                  r_core_en <= 1'b1;
                end else begin
                  r_state    <= RUN_RST;
                  r_core_rst <= 1'b1;
                end
              end
              default: begin
                // HALT while idle has nothing to stop
              end
            endcase
          end
        end

        L_ADDR: begin
          if (w_frame_valid) begin
            // address narrower than a frame: upper payload bits are dropped
            r_mem_addr <= w_frame_data[ADDR_W-1:0];
            r_state    <= L_LO;
          end
        end

        L_LO: begin
          if (w_frame_valid) begin
            r_mem_wdata[FRAME_W-1:0] <= w_frame_data;
            r_state                  <= L_HI;
          end
        end

        L_HI: begin
          if (w_frame_valid) begin
            r_mem_wdata[INSTR_W-1:FRAME_W] <= w_frame_data;
            r_mem_we                       <= 1'b1;
            r_state                        <= WRITE;
          end
        end

        WRITE: begin
          // frame spacing guarantees no frame lands in this cycle
          if (r_words_loaded != 8'hFF) begin
            r_words_loaded <= r_words_loaded + 8'd1;
          end
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        RUN_RST: begin
          r_core_en <= 1'b1;
          r_state   <= RUN;
        end

        RUN: begin
          // only HALT is honoured while running; LOAD is locked out here
          if (w_frame_valid && (w_op == OP_HALT)) begin
            r_state <= IDLE;
          end else begin
            r_core_en <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign core_en      = r_core_en;
  assign core_rst     = r_core_rst;
  assign busy         = r_busy;
  assign words_loaded = r_words_loaded;
  assign state_o      = r_state;

endmodule
